scan_test_controller: RTL and testbench
=======================================

# scan_test_controller

Sequencer for a single scan chain built from scan-equipped flops that shift scan_in into bit 0 and present the chain MSB on scan_out. For each pattern it runs one load/capture/unload test:
- shifts a parallel stimulus word into the chain;
- releases scan_en for a programmable number of functional capture cycles;
- shifts the captured response out and compares it against an expected word.

It sits between the test host (pattern source and result sink) and the chain's scan_en / scan_in / scan_out pins. It reports a pass/fail verdict, the mismatch bits and a running fail count.

## Interface
Parameters:
- CHAIN_LEN, 2: number of flops in the chain (≥2).
- CAPTURE_CYCLES, 1: functional clocks applied between load and unload (≥1).
- CNT_W, 8: width of fail_count.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a test; accepted only in IDLE.
- pattern  in  CHAIN_LEN  stimulus; bit i ends up in chain flop i. Sampled on the accepted start.
- expected  in  CHAIN_LEN  expected captured value. Sampled on the accepted start.
- scan_en  out  1  to chain; 1 = shift mode.
- scan_in  out  1  serial data to chain bit 0.
- scan_out  in  1  chain MSB (flop CHAIN_LEN-1), combinational from chain.
- busy  out  1  test in progress.
- done  out  1  one-cycle pulse; verdict valid.
- pass  out  1  1 if response == expected. Held until the next accepted start.
- response  out  CHAIN_LEN  unloaded capture word, with bit i = chain flop i. Held like pass.
- mismatch  out  CHAIN_LEN  response ^ expected. Held like pass.
- fail_count  out  CNT_W  number of failed tests; saturates at all-ones; cleared only by rst.

## Operation
State machine: IDLE → SHIFT_IN → CAPTURE → SHIFT_OUT → DONE → IDLE.

- **IDLE**
  - scan_en=0, scan_in=0, busy=0.
  - When start=1: latch pattern and expected, clear the bit counter, go to SHIFT_IN.
- **SHIFT_IN** (CHAIN_LEN cycles)
  - scan_en=1, busy=1.
  - On shift cycle k (k=0..CHAIN_LEN-1), scan_in = pattern[CHAIN_LEN-1-k], i.e. MSB first.
  - After the last shift, go to CAPTURE.
- **CAPTURE** (CAPTURE_CYCLES cycles)
  - scan_en=0, scan_in=0, busy=1.
  - Counter runs to CAPTURE_CYCLES-1, then go to SHIFT_OUT.
- **SHIFT_OUT** (CHAIN_LEN cycles)
  - scan_en=1, scan_in=0 (zero fill), busy=1.
  - Each cycle: shift_reg <= {shift_reg[CHAIN_LEN-2:0], scan_out}. scan_out is sampled in the same cycle scan_en=1 is presented, before the chain shifts.
  - After CHAIN_LEN cycles, shift_reg equals the captured chain value.
- **DONE** (1 cycle)
  - busy=0, done=1, scan_en=0.
  - Registers updated on the DONE-entry edge: response=shift_reg, mismatch=shift_reg^expected_q, pass=(mismatch==0).
  - If the test failed and fail_count is not saturated, fail_count increments.
  - Go to IDLE. start is ignored in DONE.
- start while busy or in DONE is ignored; there is no queueing.
- pattern and expected may change freely after the accepted start.
- Counter width is $clog2(max(CHAIN_LEN, CAPTURE_CYCLES)+1). The counter clears on every state change.

## Timing
- Reset values:
  - state=IDLE, scan_en=0, scan_in=0, busy=0, done=0, pass=0, response=0, mismatch=0, fail_count=0.
  - Internal pattern/expected/shift registers are also 0.
- Reset mid-operation: the next cycle is IDLE with scan_en=0. No done pulse, no fail_count change. The chain contents are left as-is.
- Latency, with start accepted at edge T:
  - SHIFT_IN occupies cycles T+1..T+CHAIN_LEN.
  - CAPTURE occupies the next CAPTURE_CYCLES cycles.
  - SHIFT_OUT occupies the next CHAIN_LEN cycles.
  - done is high in cycle T+2·CHAIN_LEN+CAPTURE_CYCLES+1.
  - The earliest next start is accepted in the following cycle (IDLE).
- scan_en and scan_in are registered outputs; they change only on clk edges.
- start and rst asserted in the same cycle: rst wins.

## Test plan
Bench chain model: a 2-bit FSM with scan. Functional mode steps 00→01→10→00, and 11→00. CHAIN_LEN=2, CAPTURE_CYCLES=1.

1. pattern=00, expected=01, start:
   - scan_in sequence 0,0 with scan_en=1;
   - one cycle with scan_en=0;
   - two unload cycles;
   - done at T+6 with response=01, pass=1, mismatch=00, fail_count=0.
2. pattern=01, expected=10 → response=10, pass=1. Then pattern=10, expected=00 → response=00, pass=1.
3. pattern=11, expected=11 → response=00, pass=0, mismatch=11, fail_count=1. Repeating the test 300 times leaves fail_count=255 (saturated).
4. start pulsed every cycle during a test → exactly one done per test; the second test begins only from the IDLE cycle after done.
5. rst asserted during SHIFT_OUT → next cycle busy=0, scan_en=0, no done pulse, fail_count unchanged. A fresh test afterwards passes.
6. CHAIN_LEN=8, CAPTURE_CYCLES=3, with a pure shift-register chain whose capture holds its value:
   - pattern=A5, expected=A5 → done at T+20, pass=1.
   - expected=A4 → mismatch=01, pass=0.

Source files
------------

// File: rtl/scan_test_controller_if.sv
// Host and chain-pin bundle for scan_test_controller.
// The master side is the test host plus the chain; the slave side is the controller.
interface scan_test_controller_if #(
    parameter int CHAIN_LEN = 2,
    parameter int CNT_W     = 8
);
    logic                 start;
    logic [CHAIN_LEN-1:0] pattern;
    logic [CHAIN_LEN-1:0] expected;
    logic                 scan_en;
    logic                 scan_in;
    logic                 scan_out;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [CHAIN_LEN-1:0] response;
    logic [CHAIN_LEN-1:0] mismatch;
    logic [CNT_W-1:0]     fail_count;

    modport master (
        output start, pattern, expected, scan_out,
        input  scan_en, scan_in, busy, done, pass, response, mismatch, fail_count
    );

    modport slave (
        input  start, pattern, expected, scan_out,
        output scan_en, scan_in, busy, done, pass, response, mismatch, fail_count
    );
endinterface

// File: rtl/scan_test_controller.sv
// Load / capture / unload sequencer for one scan chain with pass/fail verdict.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for start; chain pins quiet
// S_SHIFT_IN| CHAIN_LEN shift cycles, pattern driven MSB first
// S_CAPTURE | CAPTURE_CYCLES functional cycles with scan_en low
// S_SHIFT_OUT| CHAIN_LEN shift cycles, scan_out collected, zero fill
// S_DONE    | one-cycle done pulse, verdict registers valid
module scan_test_controller #(
    parameter int CHAIN_LEN      = 2,
    parameter int CAPTURE_CYCLES = 1,
    parameter int CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    scan_test_controller_if.slave bus
);

    localparam int MAX_LEN = (CHAIN_LEN > CAPTURE_CYCLES) ? CHAIN_LEN : CAPTURE_CYCLES;
    localparam int CW      = $clog2(MAX_LEN + 1);

    localparam logic [CW-1:0] SHIFT_LAST = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] CAP_LAST   = CW'(CAPTURE_CYCLES - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SHIFT_IN  = 3'd1;
    localparam logic [2:0] S_CAPTURE   = 3'd2;
    localparam logic [2:0] S_SHIFT_OUT = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [CHAIN_LEN-1:0] shift_reg;
    logic [CHAIN_LEN-1:0] expected_q;
    logic [CHAIN_LEN-1:0] unload_word;
    logic [CHAIN_LEN-1:0] diff;
    logic                 scan_en_q;
    logic                 scan_in_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic [CHAIN_LEN-1:0] response_q;
    logic [CHAIN_LEN-1:0] mismatch_q;
    logic [CNT_W-1:0]     fail_count_q;

    // shift_reg carries the remaining stimulus during load and the
    // collected response during unload; both move MSB-first.
    assign unload_word = {shift_reg[CHAIN_LEN-2:0], bus.scan_out};
    assign diff        = unload_word ^ expected_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            shift_reg    <= '0;
            expected_q   <= '0;
            scan_en_q    <= 1'b0;
            scan_in_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            response_q   <= '0;
            mismatch_q   <= '0;
            fail_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state      <= S_SHIFT_IN;
                        cnt        <= '0;
                        shift_reg  <= {bus.pattern[CHAIN_LEN-2:0], 1'b0};
                        expected_q <= bus.expected;
                        scan_en_q  <= 1'b1;
                        scan_in_q  <= bus.pattern[CHAIN_LEN-1];
                        busy_q     <= 1'b1;
                    end
                end
                S_SHIFT_IN: begin
                    if (cnt == SHIFT_LAST) begin
                        state     <= S_CAPTURE;
                        cnt       <= '0;
                        scan_en_q <= 1'b0;
                        scan_in_q <= 1'b0;
                    end else begin
                        cnt       <= cnt + 1'b1;
                        scan_in_q <= shift_reg[CHAIN_LEN-1];
                        shift_reg <= {shift_reg[CHAIN_LEN-2:0], 1'b0};
                    end
                end
                S_CAPTURE: begin
                    if (cnt == CAP_LAST) begin
                        state     <= S_SHIFT_OUT;
                        cnt       <= '0;
                        scan_en_q <= 1'b1;
                        scan_in_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SHIFT_OUT: begin
                    shift_reg <= unload_word;
                    if (cnt == SHIFT_LAST) begin
                        state      <= S_DONE;
                        cnt        <= '0;
                        scan_en_q  <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        response_q <= unload_word;
                        mismatch_q <= diff;
                        pass_q     <= (diff == '0);
                        if ((diff != '0) && (fail_count_q != '1))
                            fail_count_q <= fail_count_q + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state     <= S_IDLE;
                    cnt       <= '0;
                    scan_en_q <= 1'b0;
                    scan_in_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.scan_en    = scan_en_q;
    assign bus.scan_in    = scan_in_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.response   = response_q;
    assign bus.mismatch   = mismatch_q;
    assign bus.fail_count = fail_count_q;

endmodule

// File: tb/tb_scan_test_controller.sv
// Scoreboard bench: a 2-bit FSM chain (L=2, C=1) and an 8-bit hold chain (L=8, C=3).
module tb_scan_test_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    scan_test_controller_if #(.CHAIN_LEN(2), .CNT_W(8)) ifa ();
    scan_test_controller_if #(.CHAIN_LEN(8), .CNT_W(8)) ifb ();

    scan_test_controller #(.CHAIN_LEN(2), .CAPTURE_CYCLES(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave)
    );
    scan_test_controller #(.CHAIN_LEN(8), .CAPTURE_CYCLES(3), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave)
    );

    // functional behaviour of the 2-bit chain: 00->01->10->00, 11->00
    function automatic logic [1:0] fsm_step(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    logic [1:0] chain_a = '0;
    logic [7:0] chain_b = '0;
    always @(posedge clk) chain_a <= ifa.scan_en ? {chain_a[0], ifa.scan_in} : fsm_step(chain_a);
    always @(posedge clk) if (ifb.scan_en) chain_b <= {chain_b[6:0], ifb.scan_in};
    assign ifa.scan_out = chain_a[1];
    assign ifb.scan_out = chain_b[7];

    typedef struct {
        logic [7:0] resp;
        logic [7:0] exp;
        logic [7:0] fc;
        int         due;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   fc_a = 0;
    int   fc_b = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // reference model: response is the pattern advanced through C functional steps
    task automatic push_a(input logic [1:0] pat, input logic [1:0] ex, input int due);
        exp_t e;
        e.resp = {6'b0, fsm_step(pat)};
        e.exp  = {6'b0, ex};
        if (e.resp != e.exp && fc_a < 255) fc_a++;
        e.fc  = 8'(fc_a);
        e.due = due;
        q_a.push_back(e);
    endtask

    task automatic push_b(input logic [7:0] pat, input logic [7:0] ex, input int due);
        exp_t e;
        e.resp = pat;
        e.exp  = ex;
        if (e.resp != e.exp && fc_b < 255) fc_b++;
        e.fc  = 8'(fc_b);
        e.due = due;
        q_b.push_back(e);
    endtask

    always @(negedge clk) begin
        if (ifa.done === 1'b1) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                chk("a_done_cycle", 64'(cyc), 64'(e.due));
                chk("a_response", 64'(ifa.response), 64'(e.resp));
                chk("a_mismatch", 64'(ifa.mismatch), 64'(e.resp ^ e.exp));
                chk("a_pass", 64'(ifa.pass), 64'(e.resp == e.exp));
                chk("a_fail_count", 64'(ifa.fail_count), 64'(e.fc));
            end
        end
    end

    always @(negedge clk) begin
        if (ifb.done === 1'b1) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                chk("b_done_cycle", 64'(cyc), 64'(e.due));
                chk("b_response", 64'(ifb.response), 64'(e.resp));
                chk("b_mismatch", 64'(ifb.mismatch), 64'(e.resp ^ e.exp));
                chk("b_pass", 64'(ifb.pass), 64'(e.resp == e.exp));
                chk("b_fail_count", 64'(ifb.fail_count), 64'(e.fc));
            end
        end
    end

    task automatic wait_idle_a();
        int n = 0;
        while (!(ifa.busy === 1'b0 && ifa.done === 1'b0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("a_idle_timeout", 1, 0);
    endtask

    task automatic wait_idle_b();
        int n = 0;
        while (!(ifb.busy === 1'b0 && ifb.done === 1'b0) && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (n >= 80) chk("b_idle_timeout", 1, 0);
    endtask

    // issue one test on the 2-bit chain; optionally check the pin waveform
    task automatic run_a(input logic [1:0] pat, input logic [1:0] ex, input bit check_pins);
        logic [1:0] p;
        wait_idle_a();
        p             = pat;
        ifa.start     = 1'b1;
        ifa.pattern   = pat;
        ifa.expected  = ex;
        push_a(pat, ex, cyc + 6);
        @(negedge clk);
        ifa.start    = 1'b0;
        ifa.pattern  = 2'($urandom);
        ifa.expected = 2'($urandom);
        if (check_pins) begin
            for (int i = 0; i < 5; i++) begin
                logic en_x, in_x;
                en_x = (i != 2);
                in_x = (i < 2) ? p[1 - i] : 1'b0;
                chk("a_scan_en", 64'(ifa.scan_en), 64'(en_x));
                chk("a_scan_in", 64'(ifa.scan_in), 64'(in_x));
                chk("a_busy", 64'(ifa.busy), 1);
                @(negedge clk);
            end
        end
    endtask

    task automatic run_b(input logic [7:0] pat, input logic [7:0] ex);
        wait_idle_b();
        ifb.start    = 1'b1;
        ifb.pattern  = pat;
        ifb.expected = ex;
        push_b(pat, ex, cyc + 20);
        @(negedge clk);
        ifb.start    = 1'b0;
        ifb.pattern  = 8'($urandom);
        ifb.expected = 8'($urandom);
    endtask

    initial begin
        int n;
        int base;
        logic [1:0] p2, e2;
        rst          = 1'b1;
        ifa.start    = 1'b1;
        ifa.pattern  = 2'b11;
        ifa.expected = 2'b00;
        ifb.start    = 1'b1;
        ifb.pattern  = 8'hFF;
        ifb.expected = 8'h00;
        repeat (3) @(negedge clk);
        rst       = 1'b0;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        chk("rst_scan_en", 64'(ifa.scan_en), 0);
        chk("rst_scan_in", 64'(ifa.scan_in), 0);
        chk("rst_busy", 64'(ifa.busy), 0);
        chk("rst_done", 64'(ifa.done), 0);
        chk("rst_pass", 64'(ifa.pass), 0);
        chk("rst_response", 64'(ifa.response), 0);
        chk("rst_mismatch", 64'(ifa.mismatch), 0);
        chk("rst_fail_count", 64'(ifa.fail_count), 0);
        chk("rst_b_busy", 64'(ifb.busy), 0);
        chk("rst_b_response", 64'(ifb.response), 0);
        @(negedge clk);
        chk("rst_start_ignored", 64'(ifa.busy), 0);

        run_a(2'b00, 2'b01, 1'b1);
        run_a(2'b01, 2'b10, 1'b1);
        run_a(2'b10, 2'b00, 1'b1);

        // reset while unloading: controller drops out, no verdict
        wait_idle_a();
        ifa.start   = 1'b1;
        ifa.pattern = 2'b01;
        ifa.expected = 2'b10;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_in_shift_out", 64'({ifa.busy, ifa.scan_en}), 64'(2'b11));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 64'(ifa.busy), 0);
        chk("mid_rst_scan_en", 64'(ifa.scan_en), 0);
        chk("mid_rst_done", 64'(ifa.done), 0);
        chk("mid_rst_fail_count", 64'(ifa.fail_count), 0);
        fc_a = 0;
        fc_b = 0;
        @(negedge clk);
        chk("mid_rst_no_done", 64'(ifa.done), 0);
        run_a(2'b00, 2'b01, 1'b1);

        run_b(8'hA5, 8'hA5);
        run_b(8'hA5, 8'hA4);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] p;
            logic [1:0] e;
            p = 2'($urandom);
            e = ($urandom_range(0, 1) == 1) ? fsm_step(p) : 2'($urandom);
            run_a(p, e, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] p;
            p = 8'($urandom);
            run_b(p, ($urandom_range(0, 1) == 1) ? p : 8'($urandom));
        end

        // start held high across a whole test: next test only from the IDLE after done
        wait_idle_a();
        base         = cyc;
        p2           = 2'($urandom);
        e2           = fsm_step(p2);
        ifa.start    = 1'b1;
        ifa.pattern  = 2'b11;
        ifa.expected = 2'b01;
        push_a(2'b11, 2'b01, base + 6);
        push_a(p2, e2, base + 13);
        @(negedge clk);
        ifa.pattern  = p2;
        ifa.expected = e2;
        repeat (7) @(negedge clk);
        ifa.start = 1'b0;

        for (int i = 0; i < 300; i++) run_a(2'b11, 2'b11, 1'b0);

        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 1, 0);
        chk("final_fail_count", 64'(ifa.fail_count), 255);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
